alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 Parameter N, default 8, SHALL set the operand and result width in bits; N >= 2.
REQ-002 Port clk, input, 1 bit, SHALL be the single clock.
REQ-003 Port reset, input, 1 bit, SHALL be the reset: asynchronous and active-high.
REQ-004 Port a, input, N bits, SHALL be operand A: a two's-complement integer.
REQ-005 Port b, input, N bits, SHALL be operand B: a two's-complement integer, or a signed Q1.(N-1) fraction for RMLT.
REQ-006 Port func, input, 3 bits, SHALL be the operation select.
REQ-007 Port result, output, N bits, SHALL be the operation result.
REQ-008 Port ZF, output, 1 bit, SHALL be the zero flag.

Function
REQ-009 func encodings SHALL be: RA=0, RB=1, RADD=2, RSUB=3, RAND=4, ROR=5, RXOR=6, RMLT=7. The shared alucodes include file SHALL define these codes.
REQ-010 result and ZF SHALL be purely combinational from a, b and func.
- Zero-cycle latency.
- Valid within the same clock period as any input change.
- Not registered on clk.
REQ-011 RA: result = a.
REQ-012 RB: result = b.
REQ-013 RADD: result = (a + b) mod 2^N; carry discarded, no overflow flag.
REQ-014 RSUB: result = (a - b) mod 2^N; borrow discarded.
REQ-015 RAND/ROR/RXOR: result = bitwise a&b, a|b, a^b respectively.
REQ-016 RMLT SHALL compute a signed fixed-point multiply:
- P = signed(a) * signed(b), a full 2N-bit product.
- result = P[2N-2:N-1], i.e. the product arithmetic-shifted right by N-1.
- This truncates toward minus infinity; no rounding.
REQ-017 RMLT overflow (only a = b = most-negative) SHALL wrap per REQ-016 bit selection, with no saturation. For N=8: 0x80*0x80 -> 0x80.
REQ-018 ZF SHALL be 1 exactly when result == 0, for every func value, including RA/RB and RMLT truncation to zero.
REQ-019 All 8 func codes are defined, so no default/illegal case exists. X or Z on func need not produce defined output.
REQ-020 The block SHALL contain no latches and no architecturally visible state.
REQ-021 Whatever clk or reset does, result and ZF SHALL depend only on the current a, b and func.

Reset
REQ-022 reset SHALL be accepted asynchronously and active-high, for interface uniformity with sequential blocks.
REQ-023 reset SHALL NOT alter result or ZF. No output has a reset value; outputs track inputs during and after reset.
REQ-024 Asserting or deasserting reset mid-operation, in any phase relative to clk, SHALL produce no glitch beyond normal combinational settling on a/b/func.

Verification
REQ-025 With N=8, a=5, b=17, the bench SHALL check each func, one per clock, with ZF=0 throughout:
- RA -> 0x05
- RB -> 0x11
- RADD -> 0x16
- RSUB -> 0xF4
- RAND -> 0x01
- ROR -> 0x15
- RXOR -> 0x14
REQ-026 RMLT with a=20 (0x14), b=0xE0 (-0.25) -> result 0xFB (-5), ZF=0.
REQ-027 RMLT with a=0x21 (33), b=0x90 (-0.875) -> result 0xE3 (-29, floor of -28.875), ZF=0.
REQ-028 Zero-flag cases:
- a=b=0x90, RSUB -> result 0x00, ZF=1.
- a=0xFF, b=0x01, RADD -> 0x00, ZF=1 (wrap).
REQ-029 RMLT edge cases:
- a=0x80, b=0x80 -> 0x80.
- a=0x01, b=0x40 (0.5) -> 0x00 with ZF=1.
- a=0xFF, b=0x40 -> 0xFF (floor of -0.5).
REQ-030 Concurrent assertions at every posedge clk SHALL check:
- Each func equation.
- result==0 implies ZF, and ZF implies result==0.
Toggling reset at arbitrary times SHALL leave all assertions passing.

Source files
------------

// File: rtl/alu_pkg.sv
// Operation codes shared by the ALU and every block that drives its func select.
package alu_pkg;

    localparam int unsigned FUNC_W = 3;

    localparam logic [FUNC_W-1:0] RA   = 3'd0;
    localparam logic [FUNC_W-1:0] RB   = 3'd1;
    localparam logic [FUNC_W-1:0] RADD = 3'd2;
    localparam logic [FUNC_W-1:0] RSUB = 3'd3;
    localparam logic [FUNC_W-1:0] RAND = 3'd4;
    localparam logic [FUNC_W-1:0] ROR  = 3'd5;
    localparam logic [FUNC_W-1:0] RXOR = 3'd6;
    localparam logic [FUNC_W-1:0] RMLT = 3'd7;

endpackage : alu_pkg

// File: rtl/alu.sv
// Purely combinational N-bit ALU with zero flag.
//   clk    : clock (interface uniformity only, no state is clocked)
//   reset  : async active-high reset (interface uniformity only, outputs ignore it)
//   a, b   : two's-complement operands; b is a signed Q1.(N-1) fraction for RMLT
//   func   : operation select, codes in alu_pkg
//   result : operation result, valid in the same cycle as the inputs
//   ZF     : high exactly when result is zero
module alu
    import alu_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N-1:0]      a,
    input  logic [N-1:0]      b,
    input  logic [FUNC_W-1:0] func,
    output logic [N-1:0]      result,
    output logic              ZF
);

    localparam int unsigned PW = 2 * N;

    logic signed [PW-1:0] w_a_ext;
    logic signed [PW-1:0] w_b_ext;
    logic signed [PW-1:0] w_prod;
    logic        [N-1:0]  w_mlt;
    logic                 w_unused;

    // Full-width signed product; the fractional scale is removed by bit selection.
    assign w_a_ext = {{N{a[N-1]}}, a};
    assign w_b_ext = {{N{b[N-1]}}, b};
    assign w_prod  = w_a_ext * w_b_ext;

    // Arithmetic shift right by N-1 keeping N bits: floor, no rounding, no saturation.
    assign w_mlt = w_prod[PW-2:N-1];

    // clk, reset and the discarded product bits intentionally do not reach the outputs.
    assign w_unused = ^{clk, reset, w_prod[PW-1], w_prod[N-2:0]};

    // Operation select.
    always_comb begin
        result = a;
        case (func)
            RA:   result = a;
            RB:   result = b;
            RADD: result = a + b;
            RSUB: result = a - b;
            RAND: result = a & b;
            ROR:  result = a | b;
            RXOR: result = a ^ b;
            RMLT: result = w_mlt;
            default: result = a;
        endcase
    end

    assign ZF = (result == '0);

endmodule : alu

// File: tb/tb_alu.sv
// Self-checking bench for the combinational ALU at N=8: directed vectors,
// RMLT edge cases, reset toggling and random vectors through a scoreboard.
module tb_alu;
    import alu_pkg::*;

    localparam int unsigned N = 8;

    logic         clk;
    logic         reset;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2:0]   func;
    logic [N-1:0] result;
    logic         ZF;

    int n_tests;
    int n_fail;

    logic [N-1:0] exp_r_q [$];
    logic         exp_z_q [$];
    string        tag_q   [$];

    alu #(.N(N)) dut (
        .clk    (clk),
        .reset  (reset),
        .a      (a),
        .b      (b),
        .func   (func),
        .result (result),
        .ZF     (ZF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference: integer arithmetic, floor division for RMLT.
    function automatic logic [N-1:0] model(input logic [N-1:0] ma, input logic [N-1:0] mb,
                                           input logic [2:0] mf);
        int sa;
        int sb;
        int p;
        sa = $signed(ma);
        sb = $signed(mb);
        case (mf)
            3'd0: return ma;
            3'd1: return mb;
            3'd2: return 8'(sa + sb);
            3'd3: return 8'(sa - sb);
            3'd4: return ma & mb;
            3'd5: return ma | mb;
            3'd6: return ma ^ mb;
            default: begin
                p = sa * sb;
                return 8'(p >>> 7);
            end
        endcase
    endfunction

    // Drive a vector on the falling edge and record what it must produce.
    task automatic drive(input logic [N-1:0] da, input logic [N-1:0] db, input logic [2:0] df,
                         input logic [N-1:0] er, input logic ez, input string tag);
        @(negedge clk);
        a    = da;
        b    = db;
        func = df;
        exp_r_q.push_back(er);
        exp_z_q.push_back(ez);
        tag_q.push_back(tag);
    endtask

    // Outputs are combinational: compare after settling, then pop the scoreboard.
    task automatic check_out();
        logic [N-1:0] er;
        logic         ez;
        string        tag;
        #1;
        er  = exp_r_q.pop_front();
        ez  = exp_z_q.pop_front();
        tag = tag_q.pop_front();
        n_tests++;
        assert (result === er) else begin
            n_fail++;
            $error("FAIL %s result: got %h want %h", tag, result, er);
        end
        n_tests++;
        assert (ZF === ez) else begin
            n_fail++;
            $error("FAIL %s ZF: got %b want %b", tag, ZF, ez);
        end
    endtask

    // Clock-edge check: func equation against the reference and ZF consistency.
    task automatic check_edge(input string tag);
        @(posedge clk);
        n_tests++;
        assert (result === model(a, b, func) && ZF === (result == 8'h00)) else begin
            n_fail++;
            $error("FAIL %s edge: got %h/%b want %h/%b", tag, result, ZF,
                   model(a, b, func), (model(a, b, func) == 8'h00));
        end
    endtask

    task automatic step(input logic [N-1:0] da, input logic [N-1:0] db, input logic [2:0] df,
                        input logic [N-1:0] er, input logic ez, input string tag);
        drive(da, db, df, er, ez, tag);
        check_out();
        check_edge(tag);
    endtask

    initial begin
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        logic [2:0]   rf;
        logic [N-1:0] er;
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        a       = 8'h00;
        b       = 8'h00;
        func    = RA;

        // Outputs track inputs while reset is held.
        step(8'h05, 8'h11, RADD, 8'h16, 1'b0, "reset_held_add");
        #3 reset = 1'b0;

        // One op per clock with a=5, b=17.
        step(8'h05, 8'h11, RA,   8'h05, 1'b0, "ra");
        step(8'h05, 8'h11, RB,   8'h11, 1'b0, "rb");
        step(8'h05, 8'h11, RADD, 8'h16, 1'b0, "radd");
        step(8'h05, 8'h11, RSUB, 8'hF4, 1'b0, "rsub");
        step(8'h05, 8'h11, RAND, 8'h01, 1'b0, "rand");
        step(8'h05, 8'h11, ROR,  8'h15, 1'b0, "ror");
        step(8'h05, 8'h11, RXOR, 8'h14, 1'b0, "rxor");

        // Fixed-point multiply.
        step(8'h14, 8'hE0, RMLT, 8'hFB, 1'b0, "rmlt_neg_quarter");
        step(8'h21, 8'h90, RMLT, 8'hE3, 1'b0, "rmlt_floor");

        // Zero flag.
        step(8'h90, 8'h90, RSUB, 8'h00, 1'b1, "zf_sub");
        step(8'hFF, 8'h01, RADD, 8'h00, 1'b1, "zf_add_wrap");
        step(8'h00, 8'h33, RA,   8'h00, 1'b1, "zf_ra");
        step(8'h44, 8'h00, RB,   8'h00, 1'b1, "zf_rb");

        // RMLT edges.
        step(8'h80, 8'h80, RMLT, 8'h80, 1'b0, "rmlt_minmin");
        step(8'h01, 8'h40, RMLT, 8'h00, 1'b1, "rmlt_trunc_zero");
        step(8'hFF, 8'h40, RMLT, 8'hFF, 1'b0, "rmlt_floor_neg_half");
        step(8'h7F, 8'h7F, RMLT, 8'h7E, 1'b0, "rmlt_maxmax");

        // Reset toggled mid-cycle must not disturb the outputs.
        drive(8'h21, 8'h90, RMLT, 8'hE3, 1'b0, "rst_assert_mid");
        #2 reset = 1'b1;
        check_out();
        drive(8'h5A, 8'hC3, RXOR, 8'h99, 1'b0, "rst_during");
        check_out();
        check_edge("rst_during");
        #1 reset = 1'b0;
        drive(8'h5A, 8'hC3, RAND, 8'h42, 1'b0, "rst_deassert_mid");
        #3 reset = 1'b1;
        #1 reset = 1'b0;
        check_out();
        check_edge("rst_deassert_mid");

        // Random vectors against the reference, with occasional reset pulses.
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rf = 3'($urandom_range(0, 7));
            er = model(ra, rb, rf);
            if ((i % 7) == 3) reset = ~reset;
            step(ra, rb, rf, er, (er == 8'h00), "random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_alu
